// File: rtl/rr_arb_pkg.sv
// Shared constants and helpers for the round-robin / packet-lock arbiter.
package rr_arb_pkg;

    localparam int unsigned POLICY_FIXED = 0;
    localparam int unsigned POLICY_RR    = 1;

    // Index width for v items; never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return (r == 0) ? 32'd1 : r;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotated priority encoder: first set request at or after start, wrapping at N-1.
module rr_priority_pick #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [N-1:0] grant_c,
    output logic [W-1:0] index_c
);

    logic [2*N-1:0] dbl_c;
    logic           found_c;

    always_comb begin
        int unsigned pos;
        dbl_c   = {req, req} >> start;
        found_c = 1'b0;
        pos     = 0;
        grant_c = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found_c && dbl_c[k]) begin
                found_c = 1'b1;
                pos     = 32'(start) + k;
                if (pos >= N) pos = pos - N;
            end
        end
        index_c = W'(pos);
        for (int unsigned i = 0; i < N; i++) begin
            grant_c[i] = found_c && (W'(i) == index_c);
        end
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// N-channel ready/valid arbiter with fixed or round-robin policy, packet lock
// until `last`, and a registered output stage with backpressure.
module rr_lock_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned N      = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SRC_W  = 1,
    parameter int unsigned POLICY = POLICY_RR,
    localparam int unsigned CH_W  = clog2_min1(N)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N-1:0]        io_in_valid,
    output logic [N-1:0]        io_in_ready,
    input  logic [N*SRC_W-1:0]  io_in_bits_source,
    input  logic [N*DATA_W-1:0] io_in_bits_data,
    input  logic [N-1:0]        io_in_bits_last,
    output logic                io_out_valid,
    input  logic                io_out_ready,
    output logic [SRC_W-1:0]    io_out_bits_source,
    output logic [DATA_W-1:0]   io_out_bits_data,
    output logic                io_out_bits_last,
    output logic [CH_W-1:0]     io_out_chosen
);

    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   lock_ch;
    logic              locked;
    logic [CH_W-1:0]   start_c;
    logic [N-1:0]      pick_grant_c;
    logic [CH_W-1:0]   pick_idx_c;
    logic [N-1:0]      grant_c;
    logic [CH_W-1:0]   sel_c;
    logic              load_c;
    logic              fire_c;
    logic [SRC_W-1:0]  sel_source_c;
    logic [DATA_W-1:0] sel_data_c;
    logic              sel_last_c;
    logic [CH_W-1:0]   next_ptr_c;

    // Fixed priority is a rotated search that always starts at channel 0.
    assign start_c = (POLICY == POLICY_RR) ? rr_ptr : '0;

    rr_priority_pick #(
        .N (N),
        .W (CH_W)
    ) u_pick (
        .req     (io_in_valid),
        .start   (start_c),
        .grant_c (pick_grant_c),
        .index_c (pick_idx_c)
    );

    // A held lock pins the grant to its channel even while that channel is idle.
    always_comb begin
        grant_c = '0;
        sel_c   = '0;
        if (N == 1) begin
            grant_c = '1;
        end else if (locked) begin
            sel_c = lock_ch;
            for (int unsigned i = 0; i < N; i++) begin
                grant_c[i] = (CH_W'(i) == lock_ch);
            end
        end else begin
            grant_c = pick_grant_c;
            sel_c   = pick_idx_c;
        end
    end

    assign load_c      = !io_out_valid || io_out_ready;
    assign io_in_ready = (reset && load_c) ? grant_c : '0;
    assign fire_c      = |(io_in_valid & io_in_ready);
    assign next_ptr_c  = (sel_c == CH_W'(N - 1)) ? '0 : sel_c + CH_W'(1);

    always_comb begin
        sel_source_c = '0;
        sel_data_c   = '0;
        sel_last_c   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (CH_W'(i) == sel_c) begin
                sel_source_c = io_in_bits_source[i*SRC_W +: SRC_W];
                sel_data_c   = io_in_bits_data[i*DATA_W +: DATA_W];
                sel_last_c   = io_in_bits_last[i];
            end
        end
    end

    // Output stage, packet lock and round-robin pointer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_out_valid       <= 1'b0;
            io_out_bits_source <= '0;
            io_out_bits_data   <= '0;
            io_out_bits_last   <= 1'b0;
            io_out_chosen      <= '0;
            locked             <= 1'b0;
            lock_ch            <= '0;
            rr_ptr             <= '0;
        end else begin
            if (load_c) begin
                io_out_valid <= fire_c;
                if (fire_c) begin
                    io_out_bits_source <= sel_source_c;
                    io_out_bits_data   <= sel_data_c;
                    io_out_bits_last   <= sel_last_c;
                    io_out_chosen      <= sel_c;
                end
            end
            if (fire_c) begin
                locked  <= !sel_last_c;
                lock_ch <= sel_c;
                if (POLICY == POLICY_RR && sel_last_c) rr_ptr <= next_ptr_c;
            end
        end
    end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench: a round-robin and a fixed-priority instance share one input set.
module tb_rr_lock_arbiter;
    import rr_arb_pkg::*;

    localparam int unsigned N      = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SRC_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      in_valid;
    logic [N*SRC_W-1:0]  in_source;
    logic [N*DATA_W-1:0] in_data;
    logic [N-1:0]      in_last;
    logic              out_ready;

    logic [N-1:0]      rr_in_ready, fp_in_ready;
    logic              rr_out_valid, fp_out_valid;
    logic [SRC_W-1:0]  rr_src, fp_src;
    logic [DATA_W-1:0] rr_data, fp_data;
    logic              rr_last, fp_last;
    logic [1:0]        rr_chosen, fp_chosen;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rr_lock_arbiter #(.N(N), .DATA_W(DATA_W), .SRC_W(SRC_W), .POLICY(POLICY_RR)) dut_rr (
        .clock(clk), .reset(rst_n),
        .io_in_valid(in_valid), .io_in_ready(rr_in_ready),
        .io_in_bits_source(in_source), .io_in_bits_data(in_data), .io_in_bits_last(in_last),
        .io_out_valid(rr_out_valid), .io_out_ready(out_ready),
        .io_out_bits_source(rr_src), .io_out_bits_data(rr_data), .io_out_bits_last(rr_last),
        .io_out_chosen(rr_chosen)
    );

    rr_lock_arbiter #(.N(N), .DATA_W(DATA_W), .SRC_W(SRC_W), .POLICY(POLICY_FIXED)) dut_fp (
        .clock(clk), .reset(rst_n),
        .io_in_valid(in_valid), .io_in_ready(fp_in_ready),
        .io_in_bits_source(in_source), .io_in_bits_data(in_data), .io_in_bits_last(in_last),
        .io_out_valid(fp_out_valid), .io_out_ready(out_ready),
        .io_out_bits_source(fp_src), .io_out_bits_data(fp_data), .io_out_bits_last(fp_last),
        .io_out_chosen(fp_chosen)
    );

    typedef struct {
        logic [3:0] valid;
        logic [3:0] rr_rdy;
        logic       ov;
        logic [1:0] rr_ch;
        logic [1:0] fp_ch;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ch(input int i, input logic [1:0] s, input logic [31:0] d);
        in_source[i*SRC_W +: SRC_W]   = s;
        in_data[i*DATA_W +: DATA_W]   = d;
    endtask

    // Drive inputs just after an edge, check ready, then advance one edge.
    task automatic apply(input string name, input logic [3:0] v, input logic [3:0] l,
                         input logic ordy, input logic [3:0] exp_rdy);
        in_valid  = v;
        in_last   = l;
        out_ready = ordy;
        #1;
        chk({name, "_ready"}, 32'(rr_in_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic v, input logic [1:0] ch,
                           input logic [31:0] d);
        chk({name, "_valid"}, 32'(rr_out_valid), 32'(v));
        chk({name, "_chosen"}, 32'(rr_chosen), 32'(ch));
        chk({name, "_data"}, rr_data, d);
    endtask

    initial begin
        vecs[0]  = '{4'b1111, 4'b0001, 1'b1, 2'd0, 2'd0};
        vecs[1]  = '{4'b1111, 4'b0010, 1'b1, 2'd1, 2'd0};
        vecs[2]  = '{4'b1111, 4'b0100, 1'b1, 2'd2, 2'd0};
        vecs[3]  = '{4'b1111, 4'b1000, 1'b1, 2'd3, 2'd0};
        vecs[4]  = '{4'b1111, 4'b0001, 1'b1, 2'd0, 2'd0};
        vecs[5]  = '{4'b1111, 4'b0010, 1'b1, 2'd1, 2'd0};
        vecs[6]  = '{4'b1111, 4'b0100, 1'b1, 2'd2, 2'd0};
        vecs[7]  = '{4'b1111, 4'b1000, 1'b1, 2'd3, 2'd0};
        vecs[8]  = '{4'b1010, 4'b0010, 1'b1, 2'd1, 2'd1};
        vecs[9]  = '{4'b1010, 4'b1000, 1'b1, 2'd3, 2'd1};
        vecs[10] = '{4'b1010, 4'b0010, 1'b1, 2'd1, 2'd1};
        vecs[11] = '{4'b1000, 4'b1000, 1'b1, 2'd3, 2'd3};
        vecs[12] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 2'd0};

        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_ch(i, 2'(i), 32'h100 + 32'(i));

        // Reset held with all channels requesting.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rr_valid", 32'(rr_out_valid), 32'd0);
        chk("rst_rr_ready", 32'(rr_in_ready), 32'd0);
        chk("rst_rr_chosen", 32'(rr_chosen), 32'd0);
        chk("rst_fp_valid", 32'(fp_out_valid), 32'd0);
        chk("rst_fp_ready", 32'(fp_in_ready), 32'd0);
        rst_n = 1'b1;

        // Round-robin fairness, then fixed-priority starvation and idle.
        for (int r = 0; r < 13; r++) begin
            apply($sformatf("vec%0d", r), vecs[r].valid, 4'b1111, 1'b1, vecs[r].rr_rdy);
            chk($sformatf("vec%0d_rr_valid", r), 32'(rr_out_valid), 32'(vecs[r].ov));
            chk($sformatf("vec%0d_fp_valid", r), 32'(fp_out_valid), 32'(vecs[r].ov));
            if (vecs[r].ov) begin
                chk($sformatf("vec%0d_rr_chosen", r), 32'(rr_chosen), 32'(vecs[r].rr_ch));
                chk($sformatf("vec%0d_rr_data", r), rr_data, 32'h100 + 32'(vecs[r].rr_ch));
                chk($sformatf("vec%0d_fp_chosen", r), 32'(fp_chosen), 32'(vecs[r].fp_ch));
                chk($sformatf("vec%0d_fp_data", r), fp_data, 32'h100 + 32'(vecs[r].fp_ch));
            end
        end

        // Burst lock on ch2 with a mid-packet valid drop.
        set_ch(2, 2'd2, 32'hA0);
        apply("lock_a", 4'b0100, 4'b1011, 1'b1, 4'b0100);
        chk_out("lock_a", 1'b1, 2'd2, 32'hA0);
        chk("lock_a_last", 32'(rr_last), 32'd0);
        set_ch(2, 2'd2, 32'hA1);
        apply("lock_b", 4'b0111, 4'b1011, 1'b1, 4'b0100);
        chk_out("lock_b", 1'b1, 2'd2, 32'hA1);
        apply("lock_gap", 4'b0011, 4'b1011, 1'b1, 4'b0100);
        chk("lock_gap_valid", 32'(rr_out_valid), 32'd0);
        set_ch(2, 2'd2, 32'hA2);
        apply("lock_c", 4'b0111, 4'b1111, 1'b1, 4'b0100);
        chk_out("lock_c", 1'b1, 2'd2, 32'hA2);
        chk("lock_c_last", 32'(rr_last), 32'd1);
        apply("after_lock", 4'b0011, 4'b1111, 1'b1, 4'b0001);
        chk_out("after_lock", 1'b1, 2'd0, 32'h100);

        // Backpressure holds the pending beat; release loads the next one at once.
        set_ch(1, 2'd2, 32'h1234);
        apply("bp_load", 4'b0010, 4'b1111, 1'b1, 4'b0010);
        chk_out("bp_load", 1'b1, 2'd1, 32'h1234);
        set_ch(2, 2'd1, 32'h5678);
        for (int c = 0; c < 4; c++) begin
            apply($sformatf("bp_hold%0d", c), 4'b1111, 4'b1111, 1'b0, 4'b0000);
            chk_out($sformatf("bp_hold%0d", c), 1'b1, 2'd1, 32'h1234);
            chk($sformatf("bp_hold%0d_src", c), 32'(rr_src), 32'd2);
        end
        apply("bp_release", 4'b1111, 4'b1111, 1'b1, 4'b0100);
        chk_out("bp_release", 1'b1, 2'd2, 32'h5678);
        chk("bp_release_src", 32'(rr_src), 32'd1);

        // Reset in the middle of a ch1 packet.
        set_ch(1, 2'd1, 32'hB0);
        apply("mid_b0", 4'b0010, 4'b0000, 1'b1, 4'b0010);
        chk_out("mid_b0", 1'b1, 2'd1, 32'hB0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rr_out_valid), 32'd0);
        chk("mid_rst_ready", 32'(rr_in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_ch(0, 2'd0, 32'hC0);
        apply("post_rst", 4'b0011, 4'b1111, 1'b1, 4'b0001);
        chk_out("post_rst", 1'b1, 2'd0, 32'hC0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- N-channel ready/valid arbiter; successor to the 2-input fixed-priority combinational arbiter.
- Adds selectable round-robin policy, multi-beat packet lock on `last`, real backpressure, and a registered output stage.
- Sits between several request sources (e.g. I/D cache miss queues) and a single shared memory or bus channel.
- Carries `source` and `data` through, and reports the winning channel.

Parameters:
- N, 2, number of input channels (1..16).
- DATA_W, 32, data width.
- SRC_W, 1, source-id width.
- POLICY, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- CH_W, max(1,clog2(N)), width of the chosen-index output (derived).

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- io_in_valid  in  N  per-channel valid.
- io_in_ready  out  N  per-channel ready.
- io_in_bits_source  in  N*SRC_W  channel i occupies [i*SRC_W +: SRC_W].
- io_in_bits_data  in  N*DATA_W  channel i occupies [i*DATA_W +: DATA_W].
- io_in_bits_last  in  N  final beat of packet.
- io_out_valid  out  1  registered output valid.
- io_out_ready  in  1  downstream ready.
- io_out_bits_source  out  SRC_W  registered.
- io_out_bits_data  out  DATA_W  registered.
- io_out_bits_last  out  1  registered.
- io_out_chosen  out  CH_W  registered winning channel index.

Behaviour:
- Reset (reset low, async): io_out_valid=0; all out bits=0; rr pointer=0; lock=0; lock channel=0. io_in_ready=0 while in reset.
- Load condition: `load = !io_out_valid || io_out_ready`.
- Grant (combinational, one-hot or zero):
  - Locked: grant = lock channel only, regardless of its valid. Other channels are blocked.
  - Unlocked, POLICY=0: lowest valid index.
  - Unlocked, POLICY=1: first valid index searching pointer, pointer+1, ... with wrap at N-1 -> 0.
- Ready: io_in_ready[i] = load && grant[i]. At most one ready high. Ready does not depend on io_in_valid of other channels once locked.
- Fire: fire_i = io_in_valid[i] && io_in_ready[i].
  - On fire: out regs load the channel's source/data/last and chosen=i; io_out_valid=1 next cycle.
  - If load and no fire: io_out_valid=0 next cycle.
  - If !load: out regs hold, stable while io_out_valid && !io_out_ready.
- Latency: 1 cycle input fire -> io_out_valid. Throughput: 1 beat/cycle with io_out_ready held high.
- Lock:
  - Fire with last=0: lock=1, lock channel=i.
  - Fire with last=1: lock=0.
  - Single-beat packets (last=1) never lock.
- RR pointer (POLICY=1 only):
  - Updated only on fire with last=1: pointer = (i+1) mod N.
  - Unchanged on non-last beats and idle cycles.
  - POLICY=0 ignores the pointer.
- Boundaries:
  - N=1: grant = valid-independent channel 0; CH_W=1; chosen=0.
  - Pointer wrap: i=N-1 -> pointer 0.
  - Locked channel drops valid mid-packet: no grant to others and no output until it resumes.
  - Simultaneous io_out_ready and new fire: output replaced the same edge, no bubble.
  - Reset asserted mid-packet: lock cleared, partial packet discarded, output valid dropped immediately.

Decomposition:
- Package rr_arb_pkg: POLICY_FIXED=0 and POLICY_RR=1 constants; clog2 function used for CH_W.
- One sub-module, rr_priority_pick:
  - Combinational rotated priority encoder with parameter N.
  - Inputs: request vector and start pointer.
  - Outputs: one-hot grant and index.
  - POLICY=0 is handled by tying the pointer to 0.

Test Plan (N=4, DATA_W=32, SRC_W=2 unless noted):
- Reset: hold reset low 3 cycles with all valids high -> io_out_valid=0, io_in_ready=0000, chosen=0. Release -> first fire on channel 0 with io_out_valid one cycle later.
- Round-robin fairness: POLICY=1, all 4 valid, all last=1, io_out_ready=1 for 8 cycles -> chosen sequence 0,1,2,3,0,1,2,3 with io_out_valid high every cycle after the first.
- Fixed priority: POLICY=0, channels 1 and 3 valid with single beats -> channel 1 wins every cycle and channel 3 is starved until channel 1 drops valid.
- Burst lock: ch2 sends 3 beats (data 0xA0,0xA1,0xA2; last on third) while ch0 and ch1 stay valid -> output order A0,A1,A2 from ch2 uninterrupted. Next grant is ch3 if valid, else ch0.
- Backpressure: io_out_ready=0 for 4 cycles with an output pending (data 0x1234, source 2) -> io_out_bits stable, io_in_ready=0000. Raise ready -> a new beat loads the same edge, no bubble.
- Mid-packet reset: assert reset after beat 1 of a 3-beat ch1 packet -> lock cleared, io_out_valid=0. After release, ch0 single beat is accepted immediately.
